// File: rtl/match_alu_pkg.sv
// Shared types and opcode constants for the match_alu_sched slice.
// Opcodes are matched against operand A; the FSM state enum is sched_state_t.
package match_alu_pkg;

    localparam int OP_INC = 17;
    localparam int OP_ADD = 21;
    localparam int OP_SUB = 34;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

endpackage

// File: rtl/match_alu.sv
// Combinational opcode-matching ALU: operand A selects the function.
// Ports: A, B (W-bit operands) -> XOUT (W-bit result, mod 2^W).
module match_alu
    import match_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] XOUT
);

    // if-chain rather than case: for very small W the constants may alias
    always_comb begin
        XOUT = A * B;
        if (A == W'(OP_INC)) begin
            XOUT = A + W'(1);
        end else if (A == W'(OP_ADD)) begin
            XOUT = A + B;
        end else if (A == W'(OP_SUB)) begin
            XOUT = A - B;
        end
    end

endmodule

// File: rtl/match_alu_sched.sv
// Round-robin scheduler sharing one match_alu between NREQ requesters.
// Ports: CLK, RST_N (sync, active-low), REQ_VALID/REQ_A/REQ_B/REQ_READY
// per requester, RSP_VALID/RSP_READY/RSP_ID/RSP_DATA response, BUSY.
// Define MATCH_ALU_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module match_alu_sched
    import match_alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    output logic [NREQ-1:0]   REQ_READY,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [IDW-1:0]    RSP_ID,
    output logic [W-1:0]      RSP_DATA,
    output logic              BUSY
);

    // Returns {found, index}; scanning from the far end down lets the
    // candidate closest to p overwrite the others.
    function automatic logic [IDW:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [IDW-1:0]  p
    );
        logic [IDW:0] r;
        int           j;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NREQ;
            if (v[j]) begin
                r = {1'b1, IDW'(j)};
            end
        end
        return r;
    endfunction

    sched_state_t   state;
    sched_state_t   state_n;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   alu_out;
    logic [IDW:0]   sel;
    logic           found;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] ptr_nxt;

    // In the fixed-priority build ptr never leaves 0, so the same
    // search degenerates to lowest-index-wins.
    assign sel     = rr_pick(REQ_VALID, ptr);
    assign found   = sel[IDW];
    assign gnt     = sel[IDW-1:0];
    assign ptr_nxt = (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;
    assign BUSY    = (state != IDLE);

    match_alu #(
        .W(W)
    ) u_alu (
        .A   (a_q),
        .B   (b_q),
        .XOUT(alu_out)
    );

    always_comb begin
        REQ_READY = '0;
        if (RST_N && state == IDLE && found) begin
            REQ_READY = NREQ'(1) << gnt;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (found) state_n = EXEC;
            EXEC:    state_n = RESP;
            RESP:    if (RSP_READY) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr       <= '0;
            g_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_DATA  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_q <= REQ_A[int'(gnt)*W +: W];
                        b_q <= REQ_B[int'(gnt)*W +: W];
                        g_q <= gnt;
                    end
                end
                EXEC: begin
                    RSP_DATA  <= alu_out;
                    RSP_ID    <= g_q;
                    RSP_VALID <= 1'b1;
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
`ifdef MATCH_ALU_SCHED_FIXED_PRIO_EN
                        ptr <= '0;
`else
                        ptr <= ptr_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/match_alu_sched.md
Name: match_alu_sched

Overview:
- Shares one opcode-matching ALU datapath between NREQ requesters.
- Each requester presents an operand pair (A, B) with a valid/ready handshake. The scheduler grants one requester at a time, round-robin.
- The scheduler registers the operands, evaluates the ALU and returns a tagged, registered response under backpressure.
- Sits between client request ports and the shared ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, operand/result width in bits.
- IDW, $clog2(NREQ), requester-ID width (localparam, minimum 1).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- REQ_VALID  input  NREQ  per-requester request valid.
- REQ_A  input  NREQ*W  packed operand A; requester i at bits [i*W +: W].
- REQ_B  input  NREQ*W  packed operand B, same packing.
- REQ_READY  output  NREQ  one-hot accept strobe; at most one bit high.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumer ready.
- RSP_ID  output  IDW  index of the requester the response belongs to.
- RSP_DATA  output  W  ALU result.
- BUSY  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - FSM goes to IDLE; round-robin pointer PTR goes to 0.
  - RSP_VALID, RSP_ID, RSP_DATA and BUSY go to 0.
  - REQ_READY is forced to 0 while RST_N=0.
  - Reset mid-transaction drops the in-flight request silently; no response is produced.
- ALU function (combinational, OP = operand A):
  - A==17 -> A+1.
  - A==21 -> A+B.
  - A==34 -> A-B.
  - otherwise -> low W bits of A*B.
  - All results are mod 2^W (unsigned wrap; no carry/borrow out).
- FSM states: IDLE, EXEC, RESP.
  - IDLE:
    - Grant G is the first i with REQ_VALID[i]=1, searching PTR, PTR+1, ... mod NREQ.
    - REQ_READY[G]=1 combinationally in the same cycle; the handshake completes that cycle.
    - On that edge: latch REQ_A[G], REQ_B[G] and G into internal registers; go to EXEC.
    - With no valid request, stay in IDLE and keep REQ_READY=0.
  - EXEC: register the ALU result into RSP_DATA and the latched G into RSP_ID; set RSP_VALID=1; go to RESP. REQ_READY=0.
  - RESP:
    - RSP_VALID, RSP_ID and RSP_DATA are held stable until RSP_READY=1.
    - On the handshake edge: RSP_VALID<=0, PTR<=(G+1) mod NREQ, go to IDLE.
    - REQ_READY=0 throughout.
- Timing:
  - Latency from the accept edge to the first RSP_VALID cycle: 2 edges (accept, EXEC).
  - Minimum initiation interval is 3 cycles, with RSP_READY tied high.
- REQ_READY is low in EXEC and RESP; requesters must hold their request until accepted.
- A requester deasserting REQ_VALID before it is granted is legal; it is simply not granted.
- RSP_READY asserted while RSP_VALID=0 has no effect.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
- PTR advances only on the response handshake, never on reset-aborted operations.

Optional Feature:
- Macro MATCH_ALU_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with REQ_VALID high always wins, and PTR is unused (held at 0).
- Undefined (default): round-robin as described above.
- Ports and timing are identical in both builds.

Decomposition:
- Package match_alu_pkg:
  - opcode constants OP_INC=17, OP_ADD=21, OP_SUB=34.
  - FSM state enum sched_state_t {IDLE, EXEC, RESP}.
- Sub-module match_alu:
  - purely combinational; inputs A, B (W bits); output XOUT (W bits).
  - implements the ALU function above; instantiated once inside match_alu_sched.
- Round-robin grant search is a function inside match_alu_sched.

Test Plan:
- Reset behaviour: hold RST_N=0 for 2 cycles with REQ_VALID=4'b1111 -> REQ_READY=0, RSP_VALID=0, BUSY=0, RSP_DATA=0.
- Opcode coverage, NREQ=4, W=8, only requester 2 valid:
  - (A,B)=(17,5) -> RSP_ID=2, RSP_DATA=18.
  - (21,250) -> 15 (wrap).
  - (34,40) -> 250 (borrow wrap).
  - (3,100) -> 44 (300 mod 256).
  - RSP_VALID rises exactly 2 edges after the accept.
- Round-robin: all four valid continuously, RSP_READY=1 -> accept order 0,1,2,3,0 and REQ_READY one-hot every grant; with FIXED_PRIO_EN defined -> requester 0 every time.
- Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_DATA/RSP_ID stable, no REQ_READY asserted, BUSY=1. Then RSP_READY=1 -> one handshake, IDLE the next cycle.
- Reset mid-operation: assert RST_N=0 in EXEC -> no response emitted, PTR=0. The next request from requester 1 is granted normally with RSP_ID=1.
